// File: rtl/matmul_seq_ctrl_pkg.sv
// Shared constants and FSM encoding for the 10x10 matrix-multiply sequencer.
package matmul_seq_ctrl_pkg;
  localparam int MAT_N  = 10;
  localparam int OP_W   = 8;
  localparam int RES_W  = 16;
  localparam int N_ELEM = MAT_N * MAT_N;
  localparam int N_LOAD = 2 * N_ELEM;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;
endpackage

// File: rtl/matmul_seq_ctrl.sv
// Sequencer: streams A/B bytes into operand buffers, pulses an external 10x10
// multiplier, then streams back 100 products. MATMUL_SEQ_REUSE_B_EN enables B reuse.
module matmul_seq_ctrl
  import matmul_seq_ctrl_pkg::*;
#(
  parameter int N       = 10,
  parameter int RUN_CYC = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      reuse_b,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [OP_W-1:0]           in_data,
  output logic                      mult_en,
  output logic [N_ELEM*OP_W-1:0]    mult_a,
  output logic [N_ELEM*OP_W-1:0]    mult_b,
  input  logic [N_ELEM*RES_W-1:0]   mult_result,
  input  logic                      mult_done,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [RES_W-1:0]          out_data,
  output logic                      out_last,
  output logic                      busy
);

  localparam logic [7:0] NE8      = 8'(N * N);
  localparam logic [7:0] LAST_A   = 8'(N * N - 1);
  localparam logic [7:0] LAST_B   = 8'(2 * N * N - 1);
  localparam logic [6:0] LAST_O   = 7'(N * N - 1);
  localparam logic [7:0] RUN_LAST = 8'(RUN_CYC - 1);

  state_e                    state_q;
  logic [7:0]                cnt_q;
  logic [6:0]                ocnt_q;
  logic [7:0]                run_q;
  logic [N_ELEM*OP_W-1:0]    a_q, b_q;
  logic [N_ELEM*RES_W-1:0]   res_q;
  logic                      in_ready_q, mult_en_q, out_valid_q, out_last_q;
  logic [RES_W-1:0]          out_data_q;

  logic                      in_fire;
  logic [7:0]                last_idx;
  logic [6:0]                b_idx, ocnt_nxt;
  logic [9:0]                a_bit, b_bit;
  logic [10:0]               r_bit;
  logic                      unused_ok;

`ifdef MATMUL_SEQ_REUSE_B_EN
  logic reuse_q;

  // A reuse job stops after the A half; B stays from the previous job.
  assign last_idx  = reuse_q ? LAST_A : LAST_B;
  assign unused_ok = mult_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      reuse_q <= 1'b0;
    else if (state_q == ST_IDLE && start)
      reuse_q <= reuse_b;
  end
`else
  assign last_idx  = LAST_B;
  assign unused_ok = ^{mult_done, reuse_b};
`endif

  assign in_fire  = (state_q == ST_LOAD) && in_valid && in_ready_q;
  assign b_idx    = 7'(cnt_q - NE8);
  assign a_bit    = {cnt_q[6:0], 3'b000};
  assign b_bit    = {b_idx, 3'b000};
  assign ocnt_nxt = ocnt_q + 7'd1;
  assign r_bit    = {ocnt_nxt, 4'b0000};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      ocnt_q      <= '0;
      run_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      in_ready_q  <= 1'b0;
      mult_en_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q    <= ST_LOAD;
            in_ready_q <= 1'b1;
            cnt_q      <= '0;
          end
        end
        ST_LOAD: begin
          if (in_fire) begin
            if (cnt_q < NE8) a_q[a_bit +: OP_W] <= in_data;
            else             b_q[b_bit +: OP_W] <= in_data;
            if (cnt_q == last_idx) begin
              state_q    <= ST_RUN;
              in_ready_q <= 1'b0;
              mult_en_q  <= 1'b1;
              run_q      <= '0;
              cnt_q      <= '0;
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
        end
        ST_RUN: begin
          // Capture happens on the first cycle mult_en is already low.
          if (mult_en_q) begin
            run_q <= run_q + 8'd1;
            if (run_q == RUN_LAST) mult_en_q <= 1'b0;
          end else begin
            res_q       <= mult_result;
            out_data_q  <= mult_result[RES_W-1:0];
            out_valid_q <= 1'b1;
            out_last_q  <= (LAST_O == 7'd0);
            ocnt_q      <= '0;
            state_q     <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (out_ready) begin
            if (out_last_q) begin
              state_q     <= ST_IDLE;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              ocnt_q      <= '0;
            end else begin
              ocnt_q     <= ocnt_nxt;
              out_data_q <= res_q[r_bit +: RES_W];
              out_last_q <= (ocnt_nxt == LAST_O);
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign mult_en   = mult_en_q;
  assign mult_a    = a_q;
  assign mult_b    = b_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Directed bench for matmul_seq_ctrl; the bench also plays the external multiplier.
module tb_matmul_seq_ctrl;
  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, reuse_b, in_valid, in_ready;
  logic [7:0]    in_data;
  logic          mult_en;
  logic [799:0]  mult_a, mult_b;
  logic [1599:0] mult_result = '0;
  logic          mult_done = 1'b0;
  logic          out_valid, out_ready, out_last, busy;
  logic [15:0]   out_data;

  int nvec = 0;
  int nerr = 0;

  logic [7:0]  opbuf [0:199];
  logic [15:0] got   [0:99];
  logic        glast [0:99];
  int          ngot, nbad, lat, en_cyc;
  logic        rdy_after_load;

  matmul_seq_ctrl #(.N(10), .RUN_CYC(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .reuse_b(reuse_b),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .mult_en(mult_en), .mult_a(mult_a), .mult_b(mult_b),
    .mult_result(mult_result), .mult_done(mult_done),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  // External 10x10 multiplier stand-in: products wrap at 16 bits.
  always @(posedge clk) begin
    logic [15:0] acc;
    mult_done <= mult_en;
    if (mult_en) begin
      for (int i = 0; i < 10; i++)
        for (int j = 0; j < 10; j++) begin
          acc = '0;
          for (int k = 0; k < 10; k++)
            acc = acc + 16'(mult_a[(i*10+k)*8 +: 8]) * 16'(mult_b[(k*10+j)*8 +: 8]);
          mult_result[(i*10+j)*16 +: 16] <= acc;
        end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic fill_const(input logic [7:0] av, input logic [7:0] bv);
    for (int i = 0; i < 100; i++) begin
      opbuf[i]     = av;
      opbuf[100+i] = bv;
    end
  endtask

  task automatic fill_identity();
    for (int i = 0; i < 10; i++)
      for (int j = 0; j < 10; j++) begin
        opbuf[i*10+j]     = 8'(i*10+j);
        opbuf[100+i*10+j] = (i == j) ? 8'd1 : 8'd0;
      end
  endtask

  task automatic start_job(input logic rb);
    start = 1'b1; reuse_b = rb;
    @(posedge clk); #1;
    start = 1'b0; reuse_b = 1'b0;
  endtask

  task automatic load_beats(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1; in_data = opbuf[i];
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_data = 8'h00;
  endtask

  task automatic wait_result();
    int w;
    w = 0;
    en_cyc = mult_en ? 1 : 0;
    while (!out_valid && w < 50) begin
      @(posedge clk); #1;
      w++;
      if (mult_en) en_cyc++;
    end
    lat = w;
  endtask

  task automatic drain(input bit stall, input bit poke);
    logic [15:0] pd;
    logic        pl, have_prev, rdy;
    int          cyc;
    ngot = 0; nbad = 0; have_prev = 1'b0; cyc = 0; pd = '0; pl = 1'b0;
    while (ngot < 100 && cyc < 3000) begin
      if (have_prev && (out_data !== pd || out_last !== pl)) nbad++;
      rdy = stall ? (cyc % 3 == 0) : 1'b1;
      out_ready = rdy;
      start = poke && (cyc == 5);
      if (out_valid && rdy) begin
        got[ngot] = out_data; glast[ngot] = out_last; ngot++;
        have_prev = 1'b0;
      end else if (out_valid) begin
        have_prev = 1'b1; pd = out_data; pl = out_last;
      end
      @(posedge clk); #1;
      cyc++;
    end
    out_ready = 1'b0; start = 1'b0;
  endtask

  task automatic run_job(input int nb, input logic rb, input bit stall, input bit poke);
    start_job(rb);
    load_beats(nb);
    rdy_after_load = in_ready;
    wait_result();
    lat = lat + nb;
    drain(stall, poke);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; reuse_b = 1'b0; in_valid = 1'b0;
    in_data = 8'h00; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    nvec++;
    if ({in_ready, mult_en, out_valid, out_last, busy} !== 5'b0) begin
      nerr++;
      $display("FAIL reset_flags: got %b, want 00000", {in_ready, mult_en, out_valid, out_last, busy});
    end
    nvec++;
    if (out_data !== 16'd0 || mult_a !== '0 || mult_b !== '0) begin
      nerr++;
      $display("FAIL reset_data: got out_data %0d a_zero %0b b_zero %0b, want 0 1 1",
               out_data, mult_a == '0, mult_b == '0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_ones_twos(input string tag);
    fill_const(8'd1, 8'd2);
    run_job(200, 1'b0, 1'b0, 1'b0);
    nvec++;
    if (rdy_after_load !== 1'b0) begin
      nerr++; $display("FAIL %s_ready_after_load: got %b, want 0", tag, rdy_after_load);
    end
    nvec++;
    if (lat != 203) begin nerr++; $display("FAIL %s_latency: got %0d, want 203", tag, lat); end
    nvec++;
    if (en_cyc != 2) begin nerr++; $display("FAIL %s_mult_en_cycles: got %0d, want 2", tag, en_cyc); end
    nvec++;
    if (ngot != 100) begin nerr++; $display("FAIL %s_count: got %0d, want 100", tag, ngot); end
    for (int k = 0; k < ngot; k++) begin
      nvec++;
      if (got[k] !== 16'd20 || glast[k] !== (k == 99)) begin
        nerr++;
        $display("FAIL %s_out[%0d]: got %0d last %b, want 20 last %b", tag, k, got[k], glast[k], k == 99);
      end
    end
    nvec++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      nerr++; $display("FAIL %s_idle_after: got busy %b valid %b, want 0 0", tag, busy, out_valid);
    end
  endtask

  task automatic test_identity();
    // Stray in_valid while idle must not be accepted.
    in_valid = 1'b1; in_data = 8'hAA;
    repeat (3) begin
      @(posedge clk); #1;
      nvec++;
      if (in_ready !== 1'b0 || busy !== 1'b0) begin
        nerr++; $display("FAIL idle_in_valid: got ready %b busy %b, want 0 0", in_ready, busy);
      end
    end
    in_valid = 1'b0;
    fill_identity();
    run_job(200, 1'b0, 1'b0, 1'b0);
    nvec++;
    if (ngot != 100) begin nerr++; $display("FAIL ident_count: got %0d, want 100", ngot); end
    for (int k = 0; k < ngot; k++) begin
      nvec++;
      if (got[k] !== 16'(k) || glast[k] !== (k == 99)) begin
        nerr++; $display("FAIL ident_out[%0d]: got %0d last %b, want %0d", k, got[k], glast[k], k);
      end
    end
  endtask

  task automatic test_max();
    fill_const(8'd255, 8'd255);
    run_job(200, 1'b0, 1'b0, 1'b0);
    nvec++;
    if (ngot != 100) begin nerr++; $display("FAIL max_count: got %0d, want 100", ngot); end
    for (int k = 0; k < ngot; k++) begin
      nvec++;
      if (got[k] !== 16'd60426) begin
        nerr++; $display("FAIL max_out[%0d]: got %0d, want 60426", k, got[k]);
      end
    end
  endtask

  task automatic test_stall();
    fill_identity();
    run_job(200, 1'b0, 1'b1, 1'b1);
    nvec++;
    if (ngot != 100) begin nerr++; $display("FAIL stall_count: got %0d, want 100", ngot); end
    nvec++;
    if (nbad != 0) begin nerr++; $display("FAIL stall_hold: got %0d changes, want 0", nbad); end
    for (int k = 0; k < ngot; k++) begin
      nvec++;
      if (got[k] !== 16'(k) || glast[k] !== (k == 99)) begin
        nerr++; $display("FAIL stall_out[%0d]: got %0d last %b, want %0d", k, got[k], glast[k], k);
      end
    end
    nvec++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      nerr++; $display("FAIL stall_start_ignored: got busy %b ready %b, want 0 0", busy, in_ready);
    end
  endtask

  task automatic test_reset_mid_load();
    fill_const(8'd1, 8'd2);
    start_job(1'b0);
    load_beats(57);
    rst_n = 1'b0;
    #2;
    nvec++;
    if ({busy, in_ready, mult_en, out_valid} !== 4'b0 || out_data !== 16'd0) begin
      nerr++;
      $display("FAIL midrst_flags: got %b data %0d, want 0000 data 0",
               {busy, in_ready, mult_en, out_valid}, out_data);
    end
    nvec++;
    if (mult_a !== '0) begin nerr++; $display("FAIL midrst_a_cleared: got nonzero, want 0"); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    nvec++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
      nerr++; $display("FAIL midrst_release: got busy %b ready %b valid %b, want 0 0 0",
                       busy, in_ready, out_valid);
    end
    test_ones_twos("after_rst");
  endtask

  task automatic test_reuse_b();
`ifdef MATMUL_SEQ_REUSE_B_EN
    test_ones_twos("reuse_job1");
    fill_const(8'd3, 8'd0);
    run_job(100, 1'b1, 1'b0, 1'b0);
    nvec++;
    if (lat != 103) begin nerr++; $display("FAIL reuse_latency: got %0d, want 103", lat); end
    nvec++;
    if (ngot != 100) begin nerr++; $display("FAIL reuse_count: got %0d, want 100", ngot); end
    for (int k = 0; k < ngot; k++) begin
      nvec++;
      if (got[k] !== 16'd60) begin nerr++; $display("FAIL reuse_out[%0d]: got %0d, want 60", k, got[k]); end
    end
`else
    // reuse_b has no effect: the job still takes 200 beats.
    fill_const(8'd3, 8'd2);
    run_job(200, 1'b1, 1'b0, 1'b0);
    nvec++;
    if (lat != 203) begin nerr++; $display("FAIL noreuse_latency: got %0d, want 203", lat); end
    nvec++;
    if (ngot != 100) begin nerr++; $display("FAIL noreuse_count: got %0d, want 100", ngot); end
    for (int k = 0; k < ngot; k++) begin
      nvec++;
      if (got[k] !== 16'd60) begin nerr++; $display("FAIL noreuse_out[%0d]: got %0d, want 60", k, got[k]); end
    end
`endif
  endtask

  initial begin
    test_reset();
    test_ones_twos("ones_twos");
    test_identity();
    test_max();
    test_stall();
    test_reset_mid_load();
    test_reuse_b();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/matmul_seq_ctrl.md
MATMUL_SEQ_CTRL -- requirements
Module: matmul_seq_ctrl

Interface
REQ-001 Parameter N, default 10, matrix dimension; the block SHALL support only N=10 (100 elements per matrix).
REQ-002 Parameter RUN_CYC, default 2, number of cycles the multiplier enable is held before the result is captured.
REQ-003 clk  in  1  single clock; all state SHALL update on the rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 start  in  1  one-cycle request to begin a job; honoured only in IDLE.
REQ-006 reuse_b  in  1  sampled with start; selects B-reuse mode (see REQ-030).
REQ-007 in_valid / in_ready  in / out  1 / 1  byte-stream handshake for operand load.
REQ-008 in_data  in  8  operand byte; A row-major (index i*10+j), then B row-major.
REQ-009 mult_en  out  1  enable to the 10x10 multiplier datapath.
REQ-010 mult_a, mult_b  out  800 each  packed operands; element (i,j) at bits [(i*10+j)*8 +: 8].
REQ-011 mult_result  in  1600  packed products; element (i,j) at bits [(i*10+j)*16 +: 16].
REQ-012 mult_done  in  1  multiplier done flag; monitored only, SHALL NOT gate sequencing.
REQ-013 out_valid / out_ready  out / in  1 / 1  result-stream handshake.
REQ-014 out_data  out  16  result element, row-major order.
REQ-015 out_last  out  1  high with the element at index 99.
REQ-016 busy  out  1  high in any state other than IDLE.

Function
REQ-017 FSM states SHALL be IDLE, LOAD, RUN, DRAIN.
REQ-018 IDLE->LOAD on start=1; start in any other state SHALL be ignored.
REQ-019 LOAD: in_ready=1; each in_valid&&in_ready beat SHALL write in_data to operand index cnt and increment cnt (0..199; 0..99 = A, 100..199 = B).
REQ-020 LOAD->RUN on the beat that writes the final index; in_ready SHALL be 0 the following cycle.
REQ-021 RUN: mult_en=1 for exactly RUN_CYC consecutive cycles; mult_a/mult_b SHALL be stable throughout RUN.
REQ-022 On the cycle after mult_en falls, mult_result SHALL be captured into an internal 1600-bit buffer and the FSM SHALL enter DRAIN.
REQ-023 DRAIN: out_valid=1; out_data = buffer element ocnt; ocnt increments on out_valid&&out_ready; out_data/out_last SHALL hold while out_ready=0.
REQ-024 DRAIN->IDLE on the accepted beat with out_last=1.
REQ-025 Products are modulo 2^16 as delivered by the datapath; the block SHALL NOT saturate or flag overflow.
REQ-026 Idle-cycle latency start-to-first-out_valid with back-to-back input = 200 load beats + RUN_CYC + 1 cycles.
REQ-027 in_valid outside LOAD SHALL be ignored (in_ready=0); out_ready outside DRAIN SHALL be ignored.

Reset
REQ-028 rst_n=0 SHALL immediately force IDLE, cnt=0, ocnt=0, in_ready=0, mult_en=0, out_valid=0, out_last=0, busy=0, out_data=0; operand and result buffers cleared to 0.
REQ-029 Reset asserted mid-LOAD, RUN or DRAIN SHALL discard the job; no partial output after release.

Configuration
REQ-030 Macro MATMUL_SEQ_REUSE_B_EN: when defined, start with reuse_b=1 SHALL load only indices 0..99 (A) and retain B from the previous job (LOAD->RUN after index 99); when undefined, reuse_b SHALL be ignored and every job loads 200 bytes.

Structure
REQ-031 Shared package SHALL hold N, element widths (8, 16), element counts (100, 200) and the FSM state enumeration.
REQ-032 No sub-module SHALL be required; the multiplier is instantiated externally and connected through mult_* ports.

Verification
REQ-033 A all 1, B all 2 -> 100 outputs each 20, out_last on beat 100, back to IDLE.
REQ-034 A(i,j)=i*10+j, B=identity -> out_data[k]=k for k=0..99.
REQ-035 A, B all 255 -> every output 60426 (650250 mod 65536).
REQ-036 out_ready toggled 1-of-3 cycles -> values/order identical to REQ-034, out_data stable while stalled.
REQ-037 rst_n pulsed low at load beat 57 -> IDLE, in_ready=0; fresh job afterwards yields correct REQ-033 result.
REQ-038 With MATMUL_SEQ_REUSE_B_EN: job 1 per REQ-033, job 2 reuse_b=1 with A all 3 -> 100 A beats only, outputs each 60.
